rf_port_arbiter: RTL and testbench
==================================

// Module: rf_port_arbiter
// PURPOSE
//  Shares the single read port and single write port of the 16x16 dual-port
//  register file between two requesters: A (CPU pipeline) and B (debug host).
//  - On reset, sequences a clear of all 16 entries to 0.
//  - Arbitrates each port round-robin.
//  - Forwards same-cycle write data to a colliding read.
//  - Sits between the requesters and the RF; drives all RF control/address/data pins.
// PARAMETERS
//  ADDR_W     4   RF address width (depth = 2**ADDR_W)
//  DATA_W     16  RF data width
//  INIT_ZERO  1   1: clear RF after reset; 0: skip the clear (1-cycle INIT)
// PORTS
//  clk        in   1       system clock; all state updates on posedge
//  rst        in   1       asynchronous, active-high reset
//  a_rd_req   in   1       A read request (level, held until granted)
//  a_raddr    in   ADDR_W  A read address
//  a_rd_gnt   out  1       A read granted this cycle (combinational)
//  a_rd_vld   out  1       A read data valid (cycle after grant)
//  a_rdata    out  DATA_W  A read data, meaningful only when a_rd_vld
//  a_wr_req   in   1       A write request (level, held until granted)
//  a_waddr    in   ADDR_W  A write address
//  a_wdata    in   DATA_W  A write data
//  a_wr_gnt   out  1       A write granted this cycle (combinational)
//  b_*        --   --      identical set for requester B
//  init_done  out  1       1 once the clear sequence completes
//  mem_we     out  1       to RF we
//  mem_re     out  1       to RF re
//  mem_waddr  out  ADDR_W  to RF waddr
//  mem_raddr  out  ADDR_W  to RF raddr
//  mem_wdata  out  DATA_W  to RF wdata
//  mem_rdata  in   DATA_W  from RF rdata (RF updates it on negedge clk)
// BEHAVIOUR
//  Reset (async)
//   - state=INIT, init_cnt=0, both RR pointers favour A.
//   - All gnt/vld = 0; init_done = 0; rdata regs = 0.
//   - Reset mid-transfer drops in-flight reads: no vld after reset release.
//  FSM: INIT -> RUN only
//   - INIT, INIT_ZERO=1:
//     * mem_we=1, mem_waddr=init_cnt, mem_wdata=0, mem_re=0; init_cnt++ each cycle.
//     * After init_cnt=2**ADDR_W-1 is written, go to RUN; init_done=1 from the next cycle.
//     * All gnt=0 throughout INIT; requests are held off, not dropped.
//   - INIT, INIT_ZERO=0: one cycle in INIT with no writes, then RUN.
//   - RUN: stays until rst.
//  Read arbitration (RUN)
//   - One requester: it is granted.
//   - Both requesting: grant the one not granted last on this port; pointer updates on each grant.
//   - Grant cycle: mem_re=1, mem_raddr = winner's raddr. No request: mem_re=0.
//   - Latency: x_rd_vld=1 exactly one cycle after x_rd_gnt; rdata = mem_rdata captured via negedge RF read.
//   - Back-to-back grants allowed: 1 read per cycle throughput.
//  Write arbitration (RUN)
//   - Same round-robin rule, independent pointer.
//   - Grant cycle: mem_we=1, mem_waddr/mem_wdata = winner's. No request: mem_we=0.
//   - A write is committed in its grant cycle; there is no write ack beyond gnt.
//  Collision / forwarding
//   - Read and write granted in the same cycle to the same address: the RF returns the old value.
//   - Arbiter registers a fwd flag plus wdata; next cycle x_rdata = forwarded wdata.
//   - The read returns new data, whichever requesters are involved.
//  Widths: no arithmetic except init_cnt (ADDR_W+1 bits, no wrap in RUN).
//   The pointer is 1 bit per port.
// TESTING
//  1. Reset, INIT_ZERO=1
//     -> init_done rises after 16 cycles; mem_we high 16 cycles, addr 0..15, data 0.
//     -> A read of R5 then returns 0x0000.
//  2. A writes R3=0xBEEF; next cycle A reads R3 -> a_rd_vld one cycle after gnt, a_rdata=0xBEEF.
//  3. A and B both hold rd_req 4 cycles (R1/R2 preloaded 0x1111/0x2222)
//     -> gnt order A,B,A,B; a_rdata=0x1111, b_rdata=0x2222.
//  4. Same cycle: B writes R7=0x1234, A reads R7 (old 0x0000) -> a_rdata=0x1234 (forwarded).
//  5. Requests asserted during INIT -> no gnt until init_done=1, then served in RR order.
//  6. rst pulsed the cycle after an A read grant
//     -> a_rd_vld stays 0, FSM returns to INIT, init_cnt=0.

Source files
------------

// File: rtl/rf_port_arbiter.sv
// Round-robin arbiter sharing one RF read port and one RF write port
// between requesters A and B, with reset-time clear and write forwarding.
module rf_port_arbiter #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 16,
    parameter bit INIT_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_rd_req,
    input  logic [ADDR_W-1:0] a_raddr,
    output logic              a_rd_gnt,
    output logic              a_rd_vld,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              a_wr_req,
    input  logic [ADDR_W-1:0] a_waddr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_wr_gnt,
    input  logic              b_rd_req,
    input  logic [ADDR_W-1:0] b_raddr,
    output logic              b_rd_gnt,
    output logic              b_rd_vld,
    output logic [DATA_W-1:0] b_rdata,
    input  logic              b_wr_req,
    input  logic [ADDR_W-1:0] b_waddr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_wr_gnt,
    output logic              init_done,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [0:0] S_INIT = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;
    localparam logic [ADDR_W:0] LAST = {1'b0, {ADDR_W{1'b1}}};

    logic [0:0]      state;
    logic [ADDR_W:0] init_cnt;
    logic            run;
    logic            rd_pri_b;
    logic            wr_pri_b;
    logic            fwd;

    assign run       = (state == S_RUN);
    assign init_done = run;

    // Clear sequencer: walk every address once, then stay in RUN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_INIT;
            init_cnt <= '0;
        end else if (state == S_INIT) begin
            if (INIT_ZERO)
                init_cnt <= init_cnt + 1'b1;
            if (!INIT_ZERO || init_cnt == LAST)
                state <= S_RUN;
        end
    end

    // Round-robin grants; a pointer of 1 means B wins a tie
    always_comb begin
        a_rd_gnt = run & a_rd_req & (~b_rd_req | ~rd_pri_b);
        b_rd_gnt = run & b_rd_req & (~a_rd_req | rd_pri_b);
        a_wr_gnt = run & a_wr_req & (~b_wr_req | ~wr_pri_b);
        b_wr_gnt = run & b_wr_req & (~a_wr_req | wr_pri_b);
    end

    // RF pin mux: clear pattern during INIT, grant winners in RUN
    always_comb begin
        mem_re    = a_rd_gnt | b_rd_gnt;
        mem_raddr = b_rd_gnt ? b_raddr : a_raddr;
        if (!run) begin
            mem_we    = INIT_ZERO;
            mem_waddr = init_cnt[ADDR_W-1:0];
            mem_wdata = '0;
        end else begin
            mem_we    = a_wr_gnt | b_wr_gnt;
            mem_waddr = b_wr_gnt ? b_waddr : a_waddr;
            mem_wdata = b_wr_gnt ? b_wdata : a_wdata;
        end
        fwd = mem_re & mem_we & (mem_raddr == mem_waddr);
    end

    // Read return path: the RF gives the old word on a same-address
    // collision, so the granted write data is substituted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_rd_vld <= 1'b0;
            b_rd_vld <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
        end else begin
            a_rd_vld <= a_rd_gnt;
            b_rd_vld <= b_rd_gnt;
            if (a_rd_gnt)
                a_rdata <= fwd ? mem_wdata : mem_rdata;
            if (b_rd_gnt)
                b_rdata <= fwd ? mem_wdata : mem_rdata;
        end
    end

    // Per-port round-robin pointers, updated on every grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pri_b <= 1'b0;
            wr_pri_b <= 1'b0;
        end else begin
            if (a_rd_gnt)
                rd_pri_b <= 1'b1;
            else if (b_rd_gnt)
                rd_pri_b <= 1'b0;
            if (a_wr_gnt)
                wr_pri_b <= 1'b1;
            else if (b_wr_gnt)
                wr_pri_b <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Directed bench for rf_port_arbiter with an RF model and a read-data
// scoreboard fed by the stimulus and drained by a monitor.
module tb_rf_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_rd_req, b_rd_req, a_wr_req, b_wr_req;
    logic [3:0]  a_raddr, b_raddr, a_waddr, b_waddr;
    logic [15:0] a_wdata, b_wdata;
    logic        a_rd_gnt, b_rd_gnt, a_wr_gnt, b_wr_gnt;
    logic        a_rd_vld, b_rd_vld;
    logic [15:0] a_rdata, b_rdata;
    logic        init_done, mem_we, mem_re;
    logic [3:0]  mem_waddr, mem_raddr;
    logic [15:0] mem_wdata, mem_rdata;

    int total = 0;
    int bad = 0;
    logic [15:0] qa[$];
    logic [15:0] qb[$];

    rf_port_arbiter #(.ADDR_W(4), .DATA_W(16), .INIT_ZERO(1'b1)) dut (
        .clk(clk), .rst(rst),
        .a_rd_req(a_rd_req), .a_raddr(a_raddr), .a_rd_gnt(a_rd_gnt),
        .a_rd_vld(a_rd_vld), .a_rdata(a_rdata),
        .a_wr_req(a_wr_req), .a_waddr(a_waddr), .a_wdata(a_wdata),
        .a_wr_gnt(a_wr_gnt),
        .b_rd_req(b_rd_req), .b_raddr(b_raddr), .b_rd_gnt(b_rd_gnt),
        .b_rd_vld(b_rd_vld), .b_rdata(b_rdata),
        .b_wr_req(b_wr_req), .b_waddr(b_waddr), .b_wdata(b_wdata),
        .b_wr_gnt(b_wr_gnt),
        .init_done(init_done),
        .mem_we(mem_we), .mem_re(mem_re),
        .mem_waddr(mem_waddr), .mem_raddr(mem_raddr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // RF model: write on posedge, read on negedge; seeded with junk
    logic [15:0] mem[16];
    bit seeded;
    always @(posedge clk) begin
        if (!seeded) begin
            for (int i = 0; i < 16; i++) mem[i] <= 16'hDEAD;
            seeded <= 1'b1;
        end else if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end
    always @(negedge clk) begin
        if (mem_re) mem_rdata <= mem[mem_raddr];
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every valid read is matched against the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (a_rd_vld) begin
                if (qa.size() == 0) chk("a_unexpected_vld", 1, 0);
                else chk("a_rdata", a_rdata, qa.pop_front());
            end
            if (b_rd_vld) begin
                if (qb.size() == 0) chk("b_unexpected_vld", 1, 0);
                else chk("b_rdata", b_rdata, qb.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1;
        a_rd_req = 0; b_rd_req = 0; a_wr_req = 0; b_wr_req = 0;
        a_raddr = 0; b_raddr = 0; a_waddr = 0; b_waddr = 0;
        a_wdata = 0; b_wdata = 0;
        tick();
        tick();
        @(negedge clk);
        chk("rst_init_done", init_done, 0);
        chk("rst_a_vld", a_rd_vld, 0);
        chk("rst_b_vld", b_rd_vld, 0);
        chk("rst_a_rdata", a_rdata, 0);
        tick();
        rst = 1'b0;
        // Requests raised during INIT must be held off, then served A,B
        a_rd_req = 1; a_raddr = 4'd5;
        b_rd_req = 1; b_raddr = 4'd6;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("init_we", mem_we, 1);
            chk("init_waddr", mem_waddr, i);
            chk("init_wdata", mem_wdata, 0);
            chk("init_gnt", {a_rd_gnt, b_rd_gnt}, 2'b00);
            chk("init_done_low", init_done, 0);
        end
        @(negedge clk);
        chk("init_done_high", init_done, 1);
        chk("init_rr1", {a_rd_gnt, b_rd_gnt}, 2'b10);
        qa.push_back(16'h0000);
        tick();
        a_rd_req = 0;
        @(negedge clk);
        chk("init_rr2", {a_rd_gnt, b_rd_gnt}, 2'b01);
        qb.push_back(16'h0000);
        tick();
        b_rd_req = 0;
        @(negedge clk);
        chk("idle_re", mem_re, 0);
        chk("idle_we", mem_we, 0);

        // A writes R3 then reads it back
        tick();
        a_wr_req = 1; a_waddr = 4'd3; a_wdata = 16'hBEEF;
        @(negedge clk);
        chk("wr_gnt", a_wr_gnt, 1);
        chk("wr_pins", {mem_we, mem_waddr, mem_wdata}, {1'b1, 4'd3, 16'hBEEF});
        tick();
        a_wr_req = 0;
        a_rd_req = 1; a_raddr = 4'd3;
        @(negedge clk);
        chk("rd_gnt", a_rd_gnt, 1);
        chk("rd_pins", {mem_re, mem_raddr}, {1'b1, 4'd3});
        qa.push_back(16'hBEEF);
        tick();
        a_rd_req = 0;
        @(negedge clk);
        chk("rd_latency", a_rd_vld, 1);

        // Preload R1/R2 with a write tie: B wins since A wrote last
        tick();
        a_wr_req = 1; a_waddr = 4'd1; a_wdata = 16'h1111;
        b_wr_req = 1; b_waddr = 4'd2; b_wdata = 16'h2222;
        @(negedge clk);
        chk("wr_rr1", {a_wr_gnt, b_wr_gnt}, 2'b01);
        tick();
        b_wr_req = 0;
        @(negedge clk);
        chk("wr_rr2", {a_wr_gnt, b_wr_gnt}, 2'b10);
        tick();
        a_wr_req = 0;
        // Single B read so the read pointer next favours A
        b_rd_req = 1; b_raddr = 4'd2;
        @(negedge clk);
        chk("b_single", b_rd_gnt, 1);
        qb.push_back(16'h2222);
        tick();
        b_rd_req = 0;

        // Both hold read requests for four cycles: A,B,A,B
        a_rd_req = 1; a_raddr = 4'd1;
        b_rd_req = 1; b_raddr = 4'd2;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i % 2 == 0) begin
                chk("rr_order", {a_rd_gnt, b_rd_gnt}, 2'b10);
                qa.push_back(16'h1111);
            end else begin
                chk("rr_order", {a_rd_gnt, b_rd_gnt}, 2'b01);
                qb.push_back(16'h2222);
            end
            tick();
        end
        a_rd_req = 0; b_rd_req = 0;

        // Collision: B writes R7 while A reads R7
        b_wr_req = 1; b_waddr = 4'd7; b_wdata = 16'h1234;
        a_rd_req = 1; a_raddr = 4'd7;
        @(negedge clk);
        chk("col_gnt", {a_rd_gnt, b_wr_gnt}, 2'b11);
        qa.push_back(16'h1234);
        tick();
        b_wr_req = 0; a_rd_req = 0;
        b_rd_req = 1; b_raddr = 4'd7;
        @(negedge clk);
        chk("post_col_gnt", b_rd_gnt, 1);
        qb.push_back(16'h1234);
        tick();
        b_rd_req = 0;
        tick();
        tick();

        // Reset right after an A read grant drops the read
        a_rd_req = 1; a_raddr = 4'd3;
        @(negedge clk);
        chk("pre_rst_gnt", a_rd_gnt, 1);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_vld_drop", a_rd_vld, 0);
        chk("rst_reinit", {init_done, mem_we, mem_waddr}, {1'b0, 1'b1, 4'd0});
        tick();
        rst = 1'b0;
        a_rd_req = 0;
        @(negedge clk);
        chk("post_rst_vld", a_rd_vld, 0);
        chk("post_rst_cnt", mem_waddr, 0);
        begin
            int n;
            n = 0;
            while (!init_done && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk("reinit_timeout", init_done, 1);
        end
        tick();
        a_rd_req = 1; a_raddr = 4'd3;
        @(negedge clk);
        chk("reclear_gnt", a_rd_gnt, 1);
        qa.push_back(16'h0000);
        tick();
        a_rd_req = 0;
        tick();
        tick();
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
